// File: rtl/trace_commit_buffer_if.sv
// -----------------------------------------------------------------------------
// trace_commit_buffer_if
//   Bundles the retire-side capture bus and the consumer-side drain bus of the
//   commit-trace buffer.
//
//   Signals (direction as seen by the buffer):
//     commit_valid_i  in   LANES        per-lane retire valid (lane 0 oldest)
//     commit_rec_i    in   LANES*REC_W  per-lane record, lane k at [k*REC_W +: REC_W]
//     flush_i         in   1            discard buffer contents
//     trace_ready_i   in   1            consumer accepts head record
//     trace_valid_o   out  1            head record available
//     trace_rec_o     out  REC_W        head record
//     trace_seq_o     out  SEQ_W        sequence number of head record
//     level_o         out  LVL_W        occupied entries
//     overflow_o      out  1            sticky, set on first dropped group
//     drop_count_o    out  16           dropped records, saturating
//
//   Modports:
//     master : the environment (retire stage + trace consumer)
//     slave  : the buffer itself
// -----------------------------------------------------------------------------
interface trace_commit_buffer_if #(
   parameter int LANES = 2,
   parameter int DEPTH = 16,
   parameter int SEQ_W = 32
);
   localparam int REC_W = 175;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [LANES-1:0]       commit_valid_i;
   logic [LANES*REC_W-1:0] commit_rec_i;
   logic                   flush_i;
   logic                   trace_ready_i;
   logic                   trace_valid_o;
   logic [REC_W-1:0]       trace_rec_o;
   logic [SEQ_W-1:0]       trace_seq_o;
   logic [LVL_W-1:0]       level_o;
   logic                   overflow_o;
   logic [15:0]            drop_count_o;

   modport master (
      output commit_valid_i, commit_rec_i, flush_i, trace_ready_i,
      input  trace_valid_o, trace_rec_o, trace_seq_o, level_o,
             overflow_o, drop_count_o
   );

   modport slave (
      input  commit_valid_i, commit_rec_i, flush_i, trace_ready_i,
      output trace_valid_o, trace_rec_o, trace_seq_o, level_o,
             overflow_o, drop_count_o
   );
endinterface

// File: rtl/trace_commit_buffer.sv
// -----------------------------------------------------------------------------
// trace_commit_buffer
//   Multi-lane commit-trace collector. Up to LANES retire records per cycle are
//   compacted in program order into a circular buffer and drained one per
//   cycle (first-word-fall-through) over a valid/ready handshake, each tagged
//   with a sequence number. A cycle's group is admitted all-or-nothing; a
//   rejected group still consumes sequence numbers so gaps stay visible
//   downstream, and is counted in drop_count_o / flagged on overflow_o.
//
//   Ports:
//     clk_i  in  clock
//     rst_i  in  asynchronous active-high reset
//     bus    trace_commit_buffer_if.slave (capture inputs, drain outputs,
//            level/overflow/drop status)
//
//   Parameters: LANES (commit lanes), DEPTH (entries, power of 2, >= LANES),
//               SEQ_W (sequence-number width). Record width is fixed at 175.
//
//   Optional feature: define TRACE_COMMIT_FILE_EN to print a human-readable
//   commit log line on every pop handshake (simulation only).
// -----------------------------------------------------------------------------
module trace_commit_buffer #(
   parameter int LANES = 2,
   parameter int DEPTH = 16,
   parameter int SEQ_W = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   trace_commit_buffer_if.slave bus
);
   localparam int REC_W = 175;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int N_W   = $clog2(LANES + 1);

   // ------------------------------------------------------------------------
   // Configuration checks
   // ------------------------------------------------------------------------
   generate
      if ((DEPTH < 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("trace_commit_buffer: DEPTH (%0d) must be a power of 2", DEPTH);
      end
      if (DEPTH < LANES) begin : g_bad_lanes
         $error("trace_commit_buffer: DEPTH (%0d) must be >= LANES (%0d)", DEPTH, LANES);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [LVL_W-1:0] count_q, count_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic             ovf_q, ovf_d;
   logic [15:0]      drop_q, drop_d;

   // Record and sequence storage; written by up to LANES ports per cycle,
   // read asynchronously at the head for first-word-fall-through.
   logic [REC_W-1:0] rec_mem [DEPTH];
   logic [SEQ_W-1:0] seq_mem [DEPTH];

   // ------------------------------------------------------------------------
   // Lane compaction: each valid lane lands at tail + (number of valid lanes
   // below it), so gaps in the valid mask collapse into consecutive entries.
   // ------------------------------------------------------------------------
   logic [N_W-1:0]   lane_off [LANES];
   logic [N_W-1:0]   n_push;
   logic [REC_W-1:0] lane_rec [LANES];
   logic [PTR_W-1:0] lane_addr [LANES];

   always_comb begin
      n_push = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_off[k] = n_push;
         n_push      = n_push + N_W'(bus.commit_valid_i[k]);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_rec[gi]  = bus.commit_rec_i[gi*REC_W +: REC_W];
         assign lane_addr[gi] = tail_q + PTR_W'(lane_off[gi]);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Admission / handshake decisions. Free space comes from the registered
   // count only, so a pop in the same cycle never makes room for a push.
   // ------------------------------------------------------------------------
   logic [LVL_W-1:0] free_w;
   logic             admit;
   logic             push_fire;
   logic             drop_fire;
   logic             pop_fire;
   logic             head_valid;
   logic [16:0]      drop_sum;

   assign free_w     = LVL_W'(DEPTH) - count_q;
   assign admit      = (free_w >= LVL_W'(n_push));
   assign head_valid = (count_q != '0);
   assign push_fire  = !bus.flush_i && admit && (n_push != '0);
   assign drop_fire  = !bus.flush_i && !admit;
   assign pop_fire   = !bus.flush_i && head_valid && bus.trace_ready_i;
   assign drop_sum   = {1'b0, drop_q} + 17'(n_push);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      drop_d  = drop_q;
      // Sequence numbers are consumed by every offered record, whether it is
      // stored, dropped or flushed.
      seq_d   = seq_q + SEQ_W'(n_push);

      if (bus.flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_fire) begin
            tail_d = tail_q + PTR_W'(n_push);
         end
         if (pop_fire) begin
            head_d = head_q + PTR_W'(1);
         end
         count_d = count_q + (push_fire ? LVL_W'(n_push) : '0)
                           - (pop_fire ? LVL_W'(1) : '0);
         if (drop_fire) begin
            ovf_d  = 1'b1;
            drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         seq_q   <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         seq_q   <= seq_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   // Storage is deliberately not reset. Compacted addresses are distinct per
   // lane, so the per-lane writes never collide.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < LANES; k++) begin
         if (push_fire && bus.commit_valid_i[k]) begin
            rec_mem[lane_addr[k]] <= lane_rec[k];
            seq_mem[lane_addr[k]] <= seq_q + SEQ_W'(lane_off[k]);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   logic [REC_W-1:0] head_rec;
   logic [SEQ_W-1:0] head_seq;

   assign head_rec = rec_mem[head_q];
   assign head_seq = seq_mem[head_q];

   assign bus.trace_valid_o = head_valid;
   assign bus.trace_rec_o   = head_rec;
   assign bus.trace_seq_o   = head_seq;
   assign bus.level_o       = count_q;
   assign bus.overflow_o    = ovf_q;
   assign bus.drop_count_o  = drop_q;

`ifdef TRACE_COMMIT_FILE_EN
   // ------------------------------------------------------------------------
   // Commit log printer (simulation only).
   // ------------------------------------------------------------------------
   logic [SEQ_W-1:0] log_seq_exp;
   logic [REC_W-1:0] log_rec;
   string            log_line;

   initial begin
      log_seq_exp = '0;
   end

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         log_seq_exp = '0;
      end else if (pop_fire) begin
         log_rec = head_rec;
         // A jump in sequence numbers means records were dropped or flushed.
         if (head_seq != log_seq_exp) begin
            $display("# dropped %0d", head_seq - log_seq_exp);
         end
         log_seq_exp = head_seq + SEQ_W'(1);

         log_line = $sformatf("0x%8h (0x%8h)", log_rec[31:0], log_rec[63:32]);
         if (log_rec[102]) begin
            log_line = {log_line, $sformatf(" mem 0x%8h", log_rec[137:106])};
            case (log_rec[105:104])
               2'd0:    log_line = {log_line, $sformatf(" 0x%2h", log_rec[145:138])};
               2'd1:    log_line = {log_line, $sformatf(" 0x%4h", log_rec[153:138])};
               default: log_line = {log_line, $sformatf(" 0x%8h", log_rec[169:138])};
            endcase
         end
         if (log_rec[103]) begin
            if (log_rec[174:170] != 5'd0) begin
               log_line = {log_line, $sformatf(" c1_fflags 0x%8h", {27'd0, log_rec[174:170]})};
            end
            // Single-digit register numbers get a trailing space so data aligns.
            if (log_rec[68:64] < 5'd10) log_line = {log_line, $sformatf(" f%0d ", log_rec[68:64])};
            else                        log_line = {log_line, $sformatf(" f%0d", log_rec[68:64])};
            log_line = {log_line, $sformatf(" 0x%8h", log_rec[100:69])};
            if (log_rec[101]) log_line = {log_line, $sformatf(" mem 0x%8h", log_rec[137:106])};
         end else if (log_rec[68:64] != 5'd0) begin
            if (log_rec[68:64] < 5'd10) log_line = {log_line, $sformatf(" x%0d ", log_rec[68:64])};
            else                        log_line = {log_line, $sformatf(" x%0d", log_rec[68:64])};
            log_line = {log_line, $sformatf(" 0x%8h", log_rec[100:69])};
            if (log_rec[101]) log_line = {log_line, $sformatf(" mem 0x%8h", log_rec[137:106])};
         end
         $display("%s", log_line);
      end
   end
`endif

endmodule

// File: tb/tb_trace_commit_buffer.sv
module tb_trace_commit_buffer;
   localparam int LANES = 2;
   localparam int DEPTH = 16;
   localparam int SEQ_W = 32;
   localparam int REC_W = 175;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   trace_commit_buffer_if #(.LANES(LANES), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) bus ();

   trace_commit_buffer #(.LANES(LANES), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   function automatic logic [REC_W-1:0] mk(input logic [31:0] pc);
      logic [REC_W-1:0] r;
      r         = '0;
      r[31:0]   = pc;
      r[63:32]  = ~pc;
      r[68:64]  = pc[6:2];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
      $display("check %-12s observed=0x%0h", tag, obs);
   endtask

   task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic rdy, input logic fl);
      bus.commit_valid_i = v;
      bus.commit_rec_i   = {mk(pc1), mk(pc0)};
      bus.trace_ready_i  = rdy;
      bus.flush_i        = fl;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [31:0] exp_seq [15];

   initial begin
      drive(2'b00, 0, 0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      // ---- reset state ----
      chk("rst_valid", 64'(bus.trace_valid_o), 0);
      chk("rst_level", 64'(bus.level_o), 0);
      chk("rst_ovf",   64'(bus.overflow_o), 0);
      chk("rst_drop",  64'(bus.drop_count_o), 0);

      // ---- two-lane push, then FWFT pops ----
      rst = 1'b0;
      drive(2'b11, 32'h100, 32'h104, 1'b0, 1'b0);
      @(negedge clk);
      drive(2'b00, 0, 0, 1'b0, 1'b0);
      chk("p2_valid", 64'(bus.trace_valid_o), 1);
      chk("p2_level", 64'(bus.level_o), 2);
      chk("p2_pc0",   64'(bus.trace_rec_o[31:0]), 64'h100);
      chk("p2_seq0",  64'(bus.trace_seq_o), 0);
      @(negedge clk);
      chk("hold_pc",    64'(bus.trace_rec_o[31:0]), 64'h100);
      chk("hold_instr", 64'(bus.trace_rec_o[63:32]), 64'hFFFF_FEFF);
      chk("hold_seq",   64'(bus.trace_seq_o), 0);
      drive(2'b00, 0, 0, 1'b1, 1'b0);
      @(negedge clk);
      chk("pop1_pc",    64'(bus.trace_rec_o[31:0]), 64'h104);
      chk("pop1_seq",   64'(bus.trace_seq_o), 1);
      chk("pop1_level", 64'(bus.level_o), 1);
      @(negedge clk);
      chk("pop2_valid", 64'(bus.trace_valid_o), 0);
      chk("pop2_level", 64'(bus.level_o), 0);

      // ---- lane 1 only ----
      do_reset();
      drive(2'b10, 32'hDEAD, 32'h200, 1'b0, 1'b0);
      @(negedge clk);
      drive(2'b00, 0, 0, 1'b0, 1'b0);
      chk("l1_level", 64'(bus.level_o), 1);
      chk("l1_pc",    64'(bus.trace_rec_o[31:0]), 64'h200);
      chk("l1_seq",   64'(bus.trace_seq_o), 0);

      // ---- fill to 15, overflow, exact-fit admission, full-with-pop drop ----
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(2'b11, 32'h1000 + 32'(8*i), 32'h1004 + 32'(8*i), 1'b0, 1'b0);
         @(negedge clk);
      end
      drive(2'b01, 32'h1038, 0, 1'b0, 1'b0);
      @(negedge clk);
      chk("fill_level", 64'(bus.level_o), 15);
      drive(2'b11, 32'h2000, 32'h2004, 1'b0, 1'b0);
      @(negedge clk);
      chk("ovf_level", 64'(bus.level_o), 15);
      chk("ovf_drop",  64'(bus.drop_count_o), 2);
      chk("ovf_flag",  64'(bus.overflow_o), 1);
      drive(2'b00, 0, 0, 1'b1, 1'b0);
      chk("ovf_head",  64'(bus.trace_seq_o), 0);
      @(negedge clk);
      chk("pop_level", 64'(bus.level_o), 14);
      drive(2'b11, 32'h300, 32'h304, 1'b0, 1'b0);
      @(negedge clk);
      chk("exact_level", 64'(bus.level_o), 16);
      chk("exact_drop",  64'(bus.drop_count_o), 2);
      drive(2'b01, 32'h400, 0, 1'b1, 1'b0);
      @(negedge clk);
      chk("full_level", 64'(bus.level_o), 15);
      chk("full_drop",  64'(bus.drop_count_o), 3);
      drive(2'b00, 0, 0, 1'b1, 1'b0);
      for (int j = 0; j < 13; j++) exp_seq[j] = 32'(j + 2);
      exp_seq[13] = 17;
      exp_seq[14] = 18;
      for (int j = 0; j < 15; j++) begin
         chk($sformatf("drain_seq%0d", j), 64'(bus.trace_seq_o), 64'(exp_seq[j]));
         if (j == 13) chk("drain_pc17", 64'(bus.trace_rec_o[31:0]), 64'h300);
         @(negedge clk);
      end
      chk("drain_level", 64'(bus.level_o), 0);
      chk("sticky_ovf",  64'(bus.overflow_o), 1);

      // ---- asynchronous reset mid-burst ----
      drive(2'b11, 32'h700, 32'h704, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      drive(2'b01, 32'h730, 0, 1'b0, 1'b0);
      @(negedge clk);
      drive(2'b11, 32'h740, 32'h744, 1'b0, 1'b0);
      chk("ar_level7", 64'(bus.level_o), 7);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", 64'(bus.trace_valid_o), 0);
      chk("ar_level", 64'(bus.level_o), 0);
      chk("ar_ovf",   64'(bus.overflow_o), 0);
      chk("ar_drop",  64'(bus.drop_count_o), 0);
      @(negedge clk);
      rst = 1'b0;

      // ---- continuous stream, pointer wrap ----
      for (int i = 0; i < 40; i++) begin
         drive(2'b01, 32'h5000 + 32'(4*i), 0, 1'b1, 1'b0);
         @(negedge clk);
         chk($sformatf("wrap_seq%0d", i), 64'(bus.trace_seq_o), 64'(i));
         chk($sformatf("wrap_lvl%0d", i), 64'(bus.level_o), 1);
         if (i == 20) chk("wrap_pc20", 64'(bus.trace_rec_o[31:0]), 64'h5050);
      end
      drive(2'b00, 0, 0, 1'b1, 1'b0);
      @(negedge clk);
      chk("wrap_empty", 64'(bus.level_o), 0);

      // ---- flush ----
      drive(2'b11, 32'h600, 32'h604, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      drive(2'b01, 32'h610, 0, 1'b0, 1'b0);
      @(negedge clk);
      chk("fl_level5", 64'(bus.level_o), 5);
      chk("fl_head",   64'(bus.trace_seq_o), 40);
      drive(2'b11, 32'h620, 32'h624, 1'b1, 1'b1);
      @(negedge clk);
      drive(2'b01, 32'h630, 0, 1'b0, 1'b0);
      chk("fl_level", 64'(bus.level_o), 0);
      chk("fl_valid", 64'(bus.trace_valid_o), 0);
      chk("fl_drop",  64'(bus.drop_count_o), 0);
      chk("fl_ovf",   64'(bus.overflow_o), 0);
      @(negedge clk);
      drive(2'b00, 0, 0, 1'b0, 1'b0);
      chk("fl_next_seq", 64'(bus.trace_seq_o), 47);
      chk("fl_next_pc",  64'(bus.trace_rec_o[31:0]), 64'h630);
      chk("fl_next_lvl", 64'(bus.level_o), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
